// File: rtl/rr_merge_arb_if.sv
// rr_merge_arb_if: requester-side and output-side handshake bundle of rr_merge_arb.
// The v_last field exists only when RR_MERGE_ARB_LOCK_EN is defined.
interface rr_merge_arb_if #(
    parameter int WIDTH     = 4,
    parameter int DATAWIDTH = 32,
    parameter int IDW       = $clog2(WIDTH)
);
    logic [WIDTH-1:0]     v_vld;
    logic [DATAWIDTH-1:0] v_pld [WIDTH];
`ifdef RR_MERGE_ARB_LOCK_EN
    logic [WIDTH-1:0]     v_last;
`endif
    logic [WIDTH-1:0]     v_rdy;
    logic                 vld;
    logic [DATAWIDTH-1:0] pld;
    logic [IDW-1:0]       id;
    logic                 rdy;
`ifdef RR_MERGE_ARB_LOCK_EN
    modport slave (input v_vld, v_pld, v_last, rdy, output v_rdy, vld, pld, id);
    modport master (output v_vld, v_pld, v_last, rdy, input v_rdy, vld, pld, id);
`else
    modport slave (input v_vld, v_pld, rdy, output v_rdy, vld, pld, id);
    modport master (output v_vld, v_pld, rdy, input v_rdy, vld, pld, id);
`endif
endinterface

// File: rtl/rr_merge_arb.sv
// rr_merge_arb: round-robin arbiter merging WIDTH vld/pld/rdy requesters into one registered output channel.
// Defining RR_MERGE_ARB_LOCK_EN holds the grant on one requester until its v_last beat.
module rr_merge_arb #(
    parameter int WIDTH     = 4,
    parameter int DATAWIDTH = 32,
    parameter int IDW       = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    rr_merge_arb_if.slave bus
);
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       g;
    logic [IDW-1:0]       c;
    logic [IDW-1:0]       g_nxt;
    logic                 hit;
    logic                 pipe_rdy;
    logic                 xfer;
    logic                 vld_q;
    logic [DATAWIDTH-1:0] pld_q;
    logic [IDW-1:0]       id_q;
`ifdef RR_MERGE_ARB_LOCK_EN
    logic                 lock;
    logic [IDW-1:0]       lock_id;
`endif

    assign pipe_rdy  = !vld_q || bus.rdy;
    assign xfer      = hit && pipe_rdy;
    assign g_nxt     = (int'(g) == WIDTH - 1) ? '0 : g + 1'b1;
    assign bus.v_rdy = (hit && pipe_rdy && !rst) ? WIDTH'(1) << g : '0;
    assign bus.vld   = vld_q;
    assign bus.pld   = pld_q;
    assign bus.id    = id_q;

    // grant the first valid requester at or after ptr; scanning backwards lets the nearest one win
    always_comb begin
        g   = ptr;
        c   = '0;
        hit = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            c = IDW'((int'(ptr) + k) % WIDTH);
            if (bus.v_vld[c]) begin
                g   = c;
                hit = 1'b1;
            end
        end
`ifdef RR_MERGE_ARB_LOCK_EN
        if (lock) begin
            g   = lock_id;
            hit = bus.v_vld[lock_id];
        end
`endif
    end

    // output register, rotating pointer and packet lock; drain only when nothing refills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            pld_q   <= '0;
            id_q    <= '0;
            ptr     <= '0;
`ifdef RR_MERGE_ARB_LOCK_EN
            lock    <= 1'b0;
            lock_id <= '0;
`endif
        end else if (xfer) begin
            vld_q   <= 1'b1;
            pld_q   <= bus.v_pld[g];
            id_q    <= g;
`ifdef RR_MERGE_ARB_LOCK_EN
            lock    <= !bus.v_last[g];
            lock_id <= g;
            if (bus.v_last[g]) ptr <= g_nxt;
`else
            ptr     <= g_nxt;
`endif
        end else if (bus.rdy) begin
            vld_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_merge_arb.sv
// tb_rr_merge_arb: directed bench for rr_merge_arb with WIDTH=4, DATAWIDTH=32.
module tb_rr_merge_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int          n [4];
    int          s [4];
    bit          lock_pkt = 1'b0;
    logic [3:0]  acc_s = '0;
    logic [3:0]  pend_q = '0;
    logic [31:0] pld_q [4];
    int          exp_pkt [4];

    rr_merge_arb_if #(.WIDTH(4), .DATAWIDTH(32)) bus ();
    rr_merge_arb #(.WIDTH(4), .DATAWIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // record accepted beats and enforce the requester hold contract
    always @(posedge clk) begin
        acc_s = bus.v_vld & bus.v_rdy;
        for (int i = 0; i < 4; i++)
            if (pend_q[i] && !rst)
                assert (bus.v_vld[i] && bus.v_pld[i] == pld_q[i])
                else $error("requester %0d dropped or changed a pending beat", i);
        pend_q = rst ? 4'b0 : bus.v_vld & ~bus.v_rdy;
        for (int i = 0; i < 4; i++) pld_q[i] = bus.v_pld[i];
    end

    function automatic logic [31:0] pv(int i, int q);
        return {16'(i), 16'(q)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.v_vld[i] = n[i] != 0;
            bus.v_pld[i] = pv(i, s[i]);
`ifdef RR_MERGE_ARB_LOCK_EN
            bus.v_last[i] = !(lock_pkt && i == 0 && n[i] > 1);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acc_s[i]) begin
                n[i]--;
                s[i]++;
            end
        drive();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            n[i] = 3;
            s[i] = 0;
        end
        bus.rdy = 1'b1;
        drive();
        #1;
        chk("rst_v_rdy", bus.v_rdy, 4'b0000);
        chk("rst_vld", bus.vld, 1'b0);
        chk("rst_pld", bus.pld, 32'h0);
        chk("rst_id", bus.id, 2'd0);
        tick();
        tick();
        chk("rst_hold_v_rdy", bus.v_rdy, 4'b0000);
        chk("rst_hold_vld", bus.vld, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant", bus.v_rdy, 4'b0001);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("load_vld", bus.vld, 1'b1);
            chk("load_id", bus.id, 64'(k % 4));
            chk("load_pld", bus.pld, pv(k % 4, k / 4));
        end
        bus.rdy = 1'b0;
        #1;
        chk("stall_v_rdy", bus.v_rdy, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_v_rdy", bus.v_rdy, 4'b0000);
            chk("stall_vld", bus.vld, 1'b1);
            chk("stall_id", bus.id, 2'd2);
            chk("stall_pld", bus.pld, pv(2, 2));
        end
        bus.rdy = 1'b1;
        #1;
        chk("unstall_v_rdy", bus.v_rdy, 4'b1000);
        tick();
        chk("unstall_id", bus.id, 2'd3);
        chk("unstall_pld", bus.pld, pv(3, 2));
        n[2] = 1;
        drive();
        tick();
        chk("wrap_pre_id", bus.id, 2'd2);
        n[0] = 1;
        n[1] = 1;
        drive();
        #1;
        chk("wrap_v_rdy0", bus.v_rdy, 4'b0001);
        tick();
        chk("wrap_id0", bus.id, 2'd0);
        chk("wrap_v_rdy1", bus.v_rdy, 4'b0010);
        tick();
        chk("wrap_id1", bus.id, 2'd1);
        chk("wrap_pld1", bus.pld, pv(1, 3));
        tick();
        chk("drain_vld", bus.vld, 1'b0);
        chk("drain_id", bus.id, 2'd1);
        chk("drain_pld", bus.pld, pv(1, 3));
        n[1] = 1;
        n[2] = 1;
        drive();
        #1;
        chk("ptr2_v_rdy", bus.v_rdy, 4'b0100);
        tick();
        chk("ptr2_id", bus.id, 2'd2);
        tick();
        chk("ptr2_next_id", bus.id, 2'd1);
`ifdef RR_MERGE_ARB_LOCK_EN
        exp_pkt = '{0, 0, 0, 1};
`else
        exp_pkt = '{0, 1, 0, 1};
`endif
        lock_pkt = 1'b1;
        n[0] = 3;
        n[1] = 2;
        drive();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pkt_id", bus.id, 64'(exp_pkt[k]));
        end
        lock_pkt = 1'b0;
        bus.rdy = 1'b0;
        drive();
        tick();
        chk("pre_rst_vld", bus.vld, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", bus.vld, 1'b0);
        chk("async_rst_id", bus.id, 2'd0);
        chk("async_rst_pld", bus.pld, 32'h0);
        chk("async_rst_v_rdy", bus.v_rdy, 4'b0000);
        n[0]++;
        n[2]++;
        drive();
        @(negedge clk);
        rst = 1'b0;
        bus.rdy = 1'b1;
        #1;
        chk("restart_v_rdy", bus.v_rdy, 4'b0001);
        tick();
        chk("restart_id", bus.id, 2'd0);
        chk("restart_vld", bus.vld, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        chk("final_vld", bus.vld, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_merge_arb.md
# rr_merge_arb

Round-robin arbiter and registered merge stage that shares one vld/pld/rdy output channel among WIDTH requesters. Each cycle it picks one valid requester, returns ready to that requester only, and captures the payload and source index into a one-entry output register. It sits in front of a downstream consumer such as a register-bus slave port or a response collector. It replaces a plain OR-merge wherever requesters can be valid at the same time.

## Interface
- WIDTH, 4: number of requesters; must be 2 or more.
- DATAWIDTH, 32: payload width.
- IDW, $clog2(WIDTH): width of the source index.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- v_vld  in  [WIDTH-1:0]  per-requester valid.
- v_pld  in  [DATAWIDTH-1:0] x [WIDTH-1:0]  per-requester payload, unpacked array.
- v_last  in  [WIDTH-1:0]  end-of-packet flag per requester. Present only with RR_MERGE_ARB_LOCK_EN.
- v_rdy  out  [WIDTH-1:0]  per-requester ready; one-hot or zero.
- vld  out  1  output valid, registered.
- pld  out  [DATAWIDTH-1:0]  output payload, registered.
- id  out  [IDW-1:0]  index of the source of pld, registered.
- rdy  in  1  downstream ready.

## Operation
- Internal state:
  - ptr [IDW-1:0]: the highest-priority index.
  - Output register: vld, pld, id.
  - lock and lock_id: only with the macro.
- Definitions:
  - pipe_rdy = !vld || rdy.
  - Grant g = the first i with v_vld[i]=1, searching ptr, ptr+1, … cyclically. Indices wrap modulo WIDTH, not modulo 2^IDW.
- Ready output:
  - v_rdy[g] = pipe_rdy; all other bits are 0.
  - v_rdy = 0 when no v_vld bit is set, or while rst is high.
- Input transfer: when v_vld[g] && v_rdy[g], on the edge vld<=1, pld<=v_pld[g], id<=g, ptr<=(g+1) mod WIDTH.
- Output drain: when vld && rdy and there is no input transfer, vld<=0. pld and id hold their values.
- Stall: when vld && !rdy, all state holds and v_rdy=0.
- v_rdy depends combinationally on v_vld, ptr, vld and rdy. Requesters must not derive v_vld from v_rdy.
- Requester contract:
  - Once v_vld[i] is asserted, it stays high with stable v_pld[i] until accepted.
  - The block does not check this; the bench asserts it.
- ptr changes only on an input transfer. Idle cycles and stalls do not move it.

## Timing
- Reset values: vld=0, pld=0, id=0, ptr=0, lock=0. v_rdy=0 while rst is high.
- Asynchronous reset in the middle of a transfer clears all state immediately, without waiting for a clock edge. An in-flight beat is lost.
- Latency: input handshake at edge N gives vld=1 with that beat's data after edge N.
- Throughput: one beat per cycle with rdy held at 1. There is no bubble when the register drains and refills on the same edge.
- Fairness: with all WIDTH requesters continuously valid, each is granted exactly once in every WIDTH consecutive transfers.

## Configuration
- RR_MERGE_ARB_LOCK_EN defined:
  - The v_last port exists.
  - A transfer from g with v_last[g]=0 sets lock=1 and lock_id=g. Grant is then forced to lock_id whatever the other requests are, and v_rdy is 0 for every other index.
  - A transfer with v_last[lock_id]=1 clears lock on that edge.
  - ptr updates to (g+1) mod WIDTH only on a transfer with v_last=1; non-last beats leave ptr unchanged.
  - A single-beat packet (v_last=1 on its first beat) never sets lock.
- RR_MERGE_ARB_LOCK_EN undefined:
  - v_last and the lock state are absent.
  - Every beat is arbitrated independently as described under Operation.

## Test plan
- Reset, WIDTH=4: rst=1 with v_vld=4'b1111 and rdy=1 -> v_rdy=0, vld=0, pld=0, id=0. After release, the first grant is index 0.
- Full load: v_vld=4'b1111, rdy=1 for 8 cycles -> id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, vld held at 1.
- Backpressure: vld=1, id=2, rdy=0 for 3 cycles -> v_rdy=0 and pld/id held. Raising rdy -> requester 3 accepted in that same cycle, and id=3 on the next edge.
- Wrap and skip: with ptr=3 (index 2 just granted) and v_vld=4'b0011 -> grants 0, then 1; ptr ends at 2.
- Lock (macro defined): requester 0 sends a 3-beat packet with v_last only on beat 3, requester 1 valid throughout -> ids 0,0,0,1. Without the macro -> ids 0,1,0,1….
- Mid-operation reset: assert rst between edges while vld=1 and rdy=0 -> vld drops to 0 before the next edge; after release, arbitration restarts from index 0.
